// File: rtl/approx_mul_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline.
package approx_mul_pkg;

  localparam int STAGES   = 3;
  localparam int OP_CNT_W = 16;

  function automatic logic [OP_CNT_W-1:0] sat_inc(input logic [OP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pp_trunc_sum.sv
// Truncated sum of the low multiplier rows: partial-product bits of weight
// below 2^T are dropped before accumulation.
module pp_trunc_sum
  import approx_mul_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 6,
  parameter int T = N - 1
) (
  input  logic [(L > 0 ? L : 1)-1:0] x_lo,
  input  logic [N-1:0]               y,
  output logic [2*N-1:0]             s
);

  localparam logic [2*N-1:0] KEEP = {(2*N){1'b1}} << T;

  logic [2*N-1:0] y_ext;

  assign y_ext = {{N{1'b0}}, y};

  always_comb begin
    s = '0;
    for (int i = 0; i < L; i++) begin
      if (x_lo[i]) begin
        s = s + ((y_ext << i) & KEEP);
      end
    end
  end

endmodule

// File: rtl/unsigned_approx_mul_pipe.sv
// Three-stage unsigned multiplier with per-transaction exact/approximate mode
// and valid/ready flow control on both sides.
module unsigned_approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int N = 8,
  parameter int L = 6,
  parameter int T = N - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        x,
  input  logic [N-1:0]        y,
  input  logic                exact,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*N-1:0]      z,
  output logic [OP_CNT_W-1:0] op_count
);

  // Low rows (x[L-1:0]) are the approximated part; the high part is always exact.
  localparam logic [N-1:0] LO_MASK = {N{1'b1}} >> (N - L);

  logic [STAGES-1:0]   vld_q, vld_d;
  logic [STAGES-1:0]   stage_en;
  logic                accept;
  logic [N-1:0]        x_q, x_d, y_q, y_d;
  logic                exact_q, exact_d;
  logic [2*N-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic [2*N-1:0]      z_q, z_d;
  logic [OP_CNT_W-1:0] op_count_q, op_count_d;
  logic [2*N-1:0]      trunc_s;
  logic [2*N-1:0]      y_ext;

  pp_trunc_sum #(.N(N), .L(L), .T(T)) u_trunc (
    .x_lo (x_q[(L > 0 ? L : 1)-1:0]),
    .y    (y_q),
    .s    (trunc_s)
  );

  assign y_ext = {{N{1'b0}}, y_q};

  // A stage may load when it is empty or its contents move on this edge.
  always_comb begin
    stage_en[2] = !vld_q[2] || out_ready;
    stage_en[1] = !vld_q[1] || stage_en[2];
    stage_en[0] = !vld_q[0] || stage_en[1];
  end

  assign in_ready = stage_en[0];
  assign accept   = in_valid && stage_en[0];

  always_comb begin
    vld_d      = vld_q;
    x_d        = x_q;
    y_d        = y_q;
    exact_d    = exact_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    z_d        = z_q;
    op_count_d = accept ? sat_inc(op_count_q) : op_count_q;

    if (stage_en[0]) begin
      vld_d[0] = accept;
      if (accept) begin
        x_d     = x;
        y_d     = y;
        exact_d = exact || (L == 0);
      end
    end

    if (stage_en[1]) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        hi_d = y_ext * {{N{1'b0}}, x_q & ~LO_MASK};
        lo_d = exact_q ? y_ext * {{N{1'b0}}, x_q & LO_MASK} : trunc_s;
      end
    end

    if (stage_en[2]) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) begin
        z_d = hi_q + lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      exact_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      z_q        <= '0;
      op_count_q <= '0;
    end else begin
      vld_q      <= vld_d;
      x_q        <= x_d;
      y_q        <= y_d;
      exact_q    <= exact_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      z_q        <= z_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = vld_q[2];
  assign z         = z_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_unsigned_approx_mul_pipe.sv
// Scoreboard bench for unsigned_approx_mul_pipe at N=8, L=6, T=7.
module tb_unsigned_approx_mul_pipe;
  import approx_mul_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        exact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [15:0] op_count;

  typedef struct packed {
    logic [15:0] zv;
    int          acc;
    logic        lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   total_acc = 0;

  unsigned_approx_mul_pipe #(.N(8), .L(6), .T(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .exact     (exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: bit-level partial products, keeping high rows and low-row bits at or above column 7.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic ex);
    logic [15:0] acc;
    if (ex) return 16'(a) * 16'(b);
    acc = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j] && (i >= 6 || i + j >= 7))
          acc = acc + (16'(1) << (i + j));
    return acc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic e, input logic [15:0] expz, input logic lat,
                               output logic fired);
    @(negedge clk);
    in_valid = v;
    x        = a;
    y        = b;
    exact    = e;
    #4;
    fired = v && in_ready;
    if (fired) begin
      exp_q.push_back('{zv: expz, acc: cyc, lat: lat});
      total_acc++;
    end
    @(posedge clk);
  endtask

  task automatic waitDrain();
    logic f;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0, f);
    checkOutput("drain queue empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every delivery and checks hold stability while stalled.
  initial begin : monitor
    exp_t        e;
    logic        held;
    logic [15:0] held_z;
    held = 1'b0;
    held_z = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold out_valid", 32'(out_valid), 32'd1);
          checkOutput("hold z", 32'(z), 32'(held_z));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected output: got z=%0d, expected no output", z);
          end else begin
            e = exp_q.pop_front();
            checkOutput("z", 32'(z), 32'(e.zv));
            if (e.lat) checkOutput("latency", 32'(cyc - e.acc), 32'(STAGES));
          end
        end
        held   = out_valid && !out_ready;
        held_z = z;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        e;
    logic [15:0] zv;
  } vec_t;

  initial begin : stimulus
    vec_t        dir_v[8];
    logic [7:0]  sx[10];
    logic [7:0]  sy[10];
    logic        f;
    int          idx;
    int          acc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        e;

    dir_v[0] = '{8'd255, 8'd255, 1'b0, 16'd64320};
    dir_v[1] = '{8'd255, 8'd255, 1'b1, 16'd65025};
    dir_v[2] = '{8'd3,   8'd5,   1'b0, 16'd0};
    dir_v[3] = '{8'd3,   8'd5,   1'b1, 16'd15};
    dir_v[4] = '{8'd1,   8'd127, 1'b0, 16'd0};
    dir_v[5] = '{8'd1,   8'd127, 1'b1, 16'd127};
    dir_v[6] = '{8'd63,  8'd128, 1'b0, 16'd8064};
    dir_v[7] = '{8'd64,  8'd3,   1'b0, 16'd192};

    sx = '{8'd17, 8'd200, 8'd99, 8'd254, 8'd7, 8'd128, 8'd63, 8'd171, 8'd42, 8'd255};
    sy = '{8'd34, 8'd13, 8'd250, 8'd3, 8'd129, 8'd77, 8'd255, 8'd90, 8'd1, 8'd200};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    exact     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset z", 32'(z), 32'd0);
    checkOutput("reset op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, dir_v[i].a, dir_v[i].b, dir_v[i].e, dir_v[i].zv, 1'b1, f);
    waitDrain();

    $display("[TB] back-to-back alternating exact");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, sx[i], sy[i], i[0], ref_mul(sx[i], sy[i], i[0]), 1'b1, f);
    waitDrain();
    #1;
    checkOutput("op_count after streams", 32'(op_count), 32'(total_acc));

    $display("[TB] output stall");
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, sx[idx], sy[idx], idx[0], ref_mul(sx[idx], sy[idx], idx[0]), 1'b0, f);
      if (f) begin
        acc++;
        idx++;
      end
    end
    #1;
    checkOutput("accepts while stalled", 32'(acc), 32'd3);
    checkOutput("in_ready when full", 32'(in_ready), 32'd0);
    checkOutput("out_valid when full", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    while (idx < 7) begin
      applyStimulus(1'b1, sx[idx], sy[idx], idx[0], ref_mul(sx[idx], sy[idx], idx[0]), 1'b0, f);
      if (f) idx++;
    end
    waitDrain();

    $display("[TB] reset with transactions in flight");
    applyStimulus(1'b1, 8'd200, 8'd100, 1'b1, 16'd20000, 1'b0, f);
    applyStimulus(1'b1, 8'd255, 8'd255, 1'b0, 16'd64320, 1'b0, f);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset op_count", 32'(op_count), 32'd0);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    total_acc = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 16'd0, 1'b0, f);
      #1;
      checkOutput("post reset out_valid", 32'(out_valid), 32'd0);
    end

    $display("[TB] op_count saturation");
    acc = 0;
    for (int g = 0; g < 70000 && acc < 65540; g++) begin
      a = 8'(acc);
      b = 8'(acc >> 8) ^ 8'h5A;
      e = acc[0];
      applyStimulus(1'b1, a, b, e, ref_mul(a, b, e), 1'b0, f);
      if (f) begin
        acc++;
        if (acc == 65534) begin
          #1;
          checkOutput("op_count near max", 32'(op_count), 32'h0000FFFE);
        end
        if (acc == 65535) begin
          #1;
          checkOutput("op_count at max", 32'(op_count), 32'h0000FFFF);
        end
      end
    end
    checkOutput("saturation accepts", 32'(acc), 32'd65540);
    waitDrain();
    #1;
    checkOutput("op_count saturated", 32'(op_count), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unsigned_approx_mul_pipe.md
UNSIGNED_APPROX_MUL_PIPE -- requirements
Module: unsigned_approx_mul_pipe

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits (4..32).
REQ-002 SHALL have parameter L, default 6, meaning count of low multiplier rows (x[L-1:0]) subject to approximation (0..N).
REQ-003 SHALL have parameter T, default N-1, meaning truncation column: approximate-row partial-product bits of weight below 2^T are discarded (0..2N-1).
REQ-004 SHALL have clk  input  1  clock; rising edge active.
REQ-005 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have in_valid  input  1  operands present.
REQ-007 SHALL have in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have x  input  N  unsigned multiplier.
REQ-009 SHALL have y  input  N  unsigned multiplicand.
REQ-010 SHALL have exact  input  1  1 = exact product, 0 = approximate product; sampled with operands.
REQ-011 SHALL have out_valid  output  1  z valid.
REQ-012 SHALL have out_ready  input  1  consumer accepts z.
REQ-013 SHALL have z  output  2N  unsigned product.
REQ-014 SHALL have op_count  output  16  saturating count of accepted transactions.

Function
REQ-015 SHALL accept a transaction on any rising edge with in_valid=1 and in_ready=1.
REQ-016 SHALL deliver a transaction on any rising edge with out_valid=1 and out_ready=1.
REQ-017 SHALL compute the exact result as z = x*y, full 2N bits, no overflow.
REQ-018 SHALL compute the approximate result as z = (y*x[N-1:L] << L) + S, S = sum of x[i]*y[j]*2^(i+j) over i<L, all j<N, with i+j>=T.
REQ-019 SHALL treat L=0 as always exact, ignoring the exact input.
REQ-020 SHALL be a 3-stage pipeline: S1 operand register, S2 high-part product and truncated low sum registered separately, S3 final add; latency 3 cycles from acceptance to out_valid with no stall.
REQ-021 SHALL sustain one transaction per cycle while out_ready=1.
REQ-022 SHALL drive in_ready = !(out_valid & !out_ready) | any-empty-stage, so bubbles are absorbed before stalling.
REQ-023 SHALL hold z and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL carry the exact flag per transaction, so mixed-mode back-to-back streams are computed individually.
REQ-025 SHALL increment op_count once per acceptance and saturate at 16'hFFFF.
REQ-026 SHALL ignore x, y and exact when in_valid=0.

Reset
REQ-027 SHALL on rst_n=0, asynchronously clear all stage-valid flags, out_valid=0, z=0, op_count=0.
REQ-028 SHALL drive in_ready=1 during and after reset.
REQ-029 SHALL discard in-flight transactions when reset asserts mid-operation; no output for them after release.

Structure
REQ-030 SHALL keep STAGES=3 and the op_count width constant in shared package approx_mul_pkg.
REQ-031 SHALL implement the truncated low sum S in one combinational sub-module, pp_trunc_sum (parameters N, L, T).
REQ-032 SHALL contain no latches or multicycle paths.

Verification
REQ-033 SHALL cover: N=8,L=6,T=7, x=255,y=255,exact=0 -> z=64320 three cycles later; exact=1 -> z=65025.
REQ-034 SHALL cover: x=3,y=5,exact=0 -> z=0; exact=1 -> z=15.
REQ-035 SHALL cover: 10 back-to-back accepts, alternating exact, out_ready=1 -> 10 results in order, one per cycle, each matching the reference model.
REQ-036 SHALL cover: out_ready=0 for 5 cycles with continuous in_valid -> exactly 3 results held, in_ready=0 once full, no loss or duplication after release.
REQ-037 SHALL cover: rst_n low for 1 cycle with 2 transactions in flight -> out_valid=0, op_count=0, no stale result afterwards.
REQ-038 SHALL cover: 65540 accepts -> op_count=16'hFFFF.
